// File: rtl/dram_pkg.sv
// Shared DRAM command-bus definitions: command encodings, refresh FSM states,
// error codes and width-derivation helpers used by the device and controller.
package dram_pkg;

  // Commands as {ras_n, cas_n, we_n}, meaningful only when cs_n=0 and clk_en=1
  localparam logic [2:0] CMD_REFRESH   = 3'b000;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_ACTIVATE  = 3'b011;
  localparam logic [2:0] CMD_WRITE     = 3'b100;
  localparam logic [2:0] CMD_READ      = 3'b101;
  localparam logic [2:0] CMD_NOP       = 3'b111;

  // Refresh FSM states
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_BUSY = 2'd1;
  localparam logic [1:0] R_DONE = 2'd2;

  // Error codes; only the first error after reset is latched
  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL      = 3'd1;
  localparam logic [2:0] ERR_ACT_OPEN     = 3'd2;
  localparam logic [2:0] ERR_PRE_MISMATCH = 3'd3;
  localparam logic [2:0] ERR_RW_CLOSED    = 3'd4;
  localparam logic [2:0] ERR_BUSY         = 3'd5;

  function automatic int column_width(input int columns, input int data_width);
    return $clog2(columns / data_width);
  endfunction

  function automatic int row_width(input int rows);
    return $clog2(rows);
  endfunction

  function automatic int bank_id_width(input int banks);
    return $clog2(banks);
  endfunction

  function automatic int addr_width(input int row_w, input int col_w);
    return (row_w > col_w) ? row_w : col_w;
  endfunction

endpackage

// File: rtl/dram_storage_array.sv
// Single-port banked word array with synchronous write and registered read.
// The array itself has no reset; only the read-data register is cleared.
module dram_storage_array
  import dram_pkg::*;
#(
  parameter int NUMBER_OF_COLUMNS = 8,
  parameter int NUMBER_OF_ROWS    = 128,
  parameter int NUMBER_OF_BANKS   = 8,
  parameter int DRAM_DATA_WIDTH   = 2,
  localparam int COLUMN_WIDTH  = column_width(NUMBER_OF_COLUMNS, DRAM_DATA_WIDTH),
  localparam int ROW_WIDTH     = row_width(NUMBER_OF_ROWS),
  localparam int BANK_ID_WIDTH = bank_id_width(NUMBER_OF_BANKS)
)(
  input  logic                       u_clk,
  input  logic                       u_rst_n,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [BANK_ID_WIDTH-1:0]   bank,
  input  logic [ROW_WIDTH-1:0]       row,
  input  logic [COLUMN_WIDTH-1:0]    col,
  input  logic [DRAM_DATA_WIDTH-1:0] wr_data,
  output logic [DRAM_DATA_WIDTH-1:0] rd_data
);

  localparam int IDX_W = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;
  localparam int DEPTH = NUMBER_OF_BANKS * NUMBER_OF_ROWS * (NUMBER_OF_COLUMNS / DRAM_DATA_WIDTH);

  logic [DRAM_DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]           idx;

  assign idx = {bank, row, col};

  // Array write; no reset so it maps onto block RAM
  always_ff @(posedge u_clk) begin
    if (wr_en) mem[idx] <= wr_data;
  end

  // Read register updates only on a successful read and holds otherwise
  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[idx];
  end

endmodule

// File: rtl/dram_device_model.sv
// DRAM device responder: decodes the command bus, tracks one open row per
// bank, runs the refresh timer and reports the first protocol error.
module dram_device_model
  import dram_pkg::*;
#(
  parameter int NUMBER_OF_COLUMNS = 8,
  parameter int NUMBER_OF_ROWS    = 128,
  parameter int NUMBER_OF_BANKS   = 8,
  parameter int DRAM_DATA_WIDTH   = 2,
  parameter int REFRESH_CYCLES    = 4,
  localparam int COLUMN_WIDTH    = column_width(NUMBER_OF_COLUMNS, DRAM_DATA_WIDTH),
  localparam int ROW_WIDTH       = row_width(NUMBER_OF_ROWS),
  localparam int BANK_ID_WIDTH   = bank_id_width(NUMBER_OF_BANKS),
  localparam int DRAM_ADDR_WIDTH = addr_width(ROW_WIDTH, COLUMN_WIDTH)
)(
  input  logic                       u_clk,
  input  logic                       u_rst_n,
  input  logic                       dram_clk_en,
  input  logic                       dram_cs_n,
  input  logic                       dram_ras_n,
  input  logic                       dram_cas_n,
  input  logic                       dram_we_n,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
  input  logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
  output logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
  output logic                       dram_refresh_done,
  output logic [NUMBER_OF_BANKS-1:0] open_banks,
  output logic                       proto_err,
  output logic [2:0]                 err_code
);

  // cnt holds the cycles left in the refresh, counting the current cycle and
  // the DONE cycle, so DONE lands REFRESH_CYCLES cycles after acceptance
  // counting the acceptance cycle itself as the first.
  localparam int CNT_W = $clog2(REFRESH_CYCLES) + 1;
  localparam bit SHORT_REFRESH = (REFRESH_CYCLES <= 2);

  logic [1:0]       ref_state;
  logic [CNT_W-1:0] ref_cnt;
  logic [ROW_WIDTH-1:0] active_row [NUMBER_OF_BANKS];

  logic [2:0] cmd;
  logic       cmd_valid;
  logic       is_act, is_pre, is_wr, is_rd, is_ref, is_illegal;
  logic       busy, bank_open, ref_start;
  logic       do_act, do_pre, do_wr, do_rd;
  logic [ROW_WIDTH-1:0]    addr_row, cur_row;
  logic [COLUMN_WIDTH-1:0] addr_col;
  logic       err_now;
  logic [2:0] err_val;

  assign cmd       = {dram_ras_n, dram_cas_n, dram_we_n};
  assign cmd_valid = dram_clk_en & ~dram_cs_n;
  assign addr_row  = dram_addr[ROW_WIDTH-1:0];
  assign addr_col  = dram_addr[COLUMN_WIDTH-1:0];
  assign cur_row   = active_row[dram_bank_id];
  assign bank_open = open_banks[dram_bank_id];
  assign busy      = (ref_state == R_BUSY);

  // One-hot command decode, gated by clock enable and chip select
  always_comb begin
    is_act     = 1'b0;
    is_pre     = 1'b0;
    is_wr      = 1'b0;
    is_rd      = 1'b0;
    is_ref     = 1'b0;
    is_illegal = 1'b0;
    if (cmd_valid) begin
      case (cmd)
        CMD_ACTIVATE:  is_act     = 1'b1;
        CMD_PRECHARGE: is_pre     = 1'b1;
        CMD_WRITE:     is_wr      = 1'b1;
        CMD_READ:      is_rd      = 1'b1;
        CMD_REFRESH:   is_ref     = 1'b1;
        CMD_NOP:       is_illegal = 1'b0;
        default:       is_illegal = 1'b1;
      endcase
    end
  end

  assign ref_start = is_ref & (ref_state == R_IDLE);
  assign do_act    = is_act & ~busy;
  assign do_pre    = is_pre & ~busy;
  assign do_wr     = is_wr & ~busy & bank_open;
  assign do_rd     = is_rd & ~busy & bank_open;

  // Classify this cycle's protocol error, if any (at most one per command)
  always_comb begin
    err_now = 1'b1;
    err_val = ERR_NONE;
    if (is_illegal)                                    err_val = ERR_ILLEGAL;
    else if ((is_act | is_pre | is_wr | is_rd) & busy) err_val = ERR_BUSY;
    else if (is_act & bank_open)                       err_val = ERR_ACT_OPEN;
    else if (is_pre & bank_open & (addr_row != cur_row)) err_val = ERR_PRE_MISMATCH;
    else if ((is_wr | is_rd) & ~bank_open)             err_val = ERR_RW_CLOSED;
    else                                               err_now = 1'b0;
  end

  // Bank open flags and active rows; refresh acceptance precharges all banks
  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      open_banks <= '0;
      for (int b = 0; b < NUMBER_OF_BANKS; b++) active_row[b] <= '0;
    end else if (ref_start) begin
      open_banks <= '0;
    end else if (do_act) begin
      open_banks[dram_bank_id] <= 1'b1;
      active_row[dram_bank_id] <= addr_row;
    end else if (do_pre) begin
      open_banks[dram_bank_id] <= 1'b0;
    end
  end

  // Refresh FSM; everything holds while clk_en is low
  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      ref_state <= R_IDLE;
      ref_cnt   <= '0;
    end else if (dram_clk_en) begin
      case (ref_state)
        R_IDLE: begin
          if (ref_start) begin
            ref_state <= SHORT_REFRESH ? R_DONE : R_BUSY;
            ref_cnt   <= CNT_W'(REFRESH_CYCLES - 1);
          end
        end
        R_BUSY: begin
          ref_cnt <= ref_cnt - CNT_W'(1);
          if (ref_cnt <= CNT_W'(2)) ref_state <= R_DONE;
        end
        R_DONE:  ref_state <= R_IDLE;
        default: ref_state <= R_IDLE;
      endcase
    end
  end

  assign dram_refresh_done = (ref_state == R_DONE);

  // Sticky error flag; the code of the first error is kept until reset
  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      proto_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (err_now && !proto_err) begin
      proto_err <= 1'b1;
      err_code  <= err_val;
    end
  end

  dram_storage_array #(
    .NUMBER_OF_COLUMNS (NUMBER_OF_COLUMNS),
    .NUMBER_OF_ROWS    (NUMBER_OF_ROWS),
    .NUMBER_OF_BANKS   (NUMBER_OF_BANKS),
    .DRAM_DATA_WIDTH   (DRAM_DATA_WIDTH)
  ) u_storage (
    .u_clk   (u_clk),
    .u_rst_n (u_rst_n),
    .wr_en   (do_wr),
    .rd_en   (do_rd),
    .bank    (dram_bank_id),
    .row     (cur_row),
    .col     (addr_col),
    .wr_data (dram_wr_data),
    .rd_data (dram_rd_data)
  );

endmodule
